// File: rtl/pc_ctrl.sv
// pc_ctrl -- next-PC and fetch-control generator for the 5-stage pipeline.
//
// Sits beside the pc register. It drives pc_in/pc_enable and reads the
// current PC back. It sequences:
//   - the reset boot,
//   - branch/jump redirects with a multi-cycle front-end flush,
//   - trapping of misaligned redirect targets,
//   - load-use stalls, with a watchdog on long stalls,
//   - halt.
// All outputs are combinational from registered state plus current inputs,
// so the pc register captures pc_next_o on the same rising edge.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   pc_cur_i         current PC from the pc register (read only)
//   stall_req_i      load-use hazard: hold IF and IF/ID, bubble ID/EX
//   redirect_valid_i branch taken / jump resolved in EX
//   redirect_pc_i    redirect target
//   halt_req_i       ecall/ebreak retired, stop fetch
//   pc_next_o        to pc register pc_in
//   pc_enable_o      to pc register pc_enable
//   stall_if_id_o    hold IF/ID register
//   flush_if_id_o    clear IF/ID to NOP
//   flush_id_ex_o    clear ID/EX to NOP
//   misalign_err_o   one-cycle pulse when a misaligned redirect is trapped
//   hang_err_o       sticky, the stall run reached MAX_STALL cycles
//   halted_o         core halted
module pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC      = 32'h0000_0010,
    parameter int          FLUSH_CYCLES = 1,   // 1..15
    parameter int          MAX_STALL    = 16   // 2..255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_cur_i,
    input  logic        stall_req_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_req_i,
    output logic [31:0] pc_next_o,
    output logic        pc_enable_o,
    output logic        stall_if_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        misalign_err_o,
    output logic        hang_err_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_LIMIT  = 8'(MAX_STALL - 1);

    state_t      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        hang_q, hang_d;

    logic [31:0] pc_seq;
    logic        redir_misaligned;
    logic        active;      // RUN or FLUSH: the states that honour halt/redirect
    logic        stall_win;   // a stall actually takes effect this cycle
    logic        hang_hit;    // this stall cycle is the MAX_STALL-th in a row

    assign pc_seq           = pc_cur_i + 32'd4;   // wraps mod 2^32
    assign redir_misaligned = (redirect_pc_i[1:0] != 2'b00);
    assign active           = (state_q == S_RUN) || (state_q == S_FLUSH);
    // Stalls are ignored in FLUSH: the stages they refer to are being squashed.
    assign stall_win        = (state_q == S_RUN) && !halt_req_i &&
                              !redirect_valid_i && stall_req_i;
    assign hang_hit         = stall_win && (stall_cnt_q == STALL_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_BOOT;
            flush_cnt_q <= 4'd0;
            stall_cnt_q <= 8'd0;
            hang_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            hang_q      <= hang_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = 8'd0;          // any non-stall cycle breaks the run
        hang_d      = hang_q | hang_hit;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_FLUSH: begin
                if (halt_req_i) begin
                    state_d = S_HALT;
                end else if (redirect_valid_i) begin
                    // A redirect restarts the flush window even mid-flush.
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_FLUSH) begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q == 4'd1) begin
                        state_d = S_RUN;
                    end
                end else if (stall_req_i) begin
                    stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF
                                                         : stall_cnt_q + 8'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_next_o      = pc_seq;
        pc_enable_o    = 1'b1;
        stall_if_id_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        misalign_err_o = 1'b0;
        halted_o       = 1'b0;
        // The flag is registered, but the cycle that trips it reports at once.
        hang_err_o     = hang_q | hang_hit;

        if (rst_i) begin
            pc_next_o     = RESET_PC;
            pc_enable_o   = 1'b0;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            hang_err_o    = 1'b0;
        end else begin
            unique case (state_q)
                S_BOOT: begin
                    pc_next_o     = RESET_PC;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
                S_RUN, S_FLUSH: begin
                    if (halt_req_i) begin
                        pc_enable_o   = 1'b0;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (redirect_valid_i) begin
                        pc_next_o      = redir_misaligned ? TRAP_PC : redirect_pc_i;
                        misalign_err_o = redir_misaligned;
                        flush_if_id_o  = 1'b1;
                        flush_id_ex_o  = 1'b1;
                    end else if (state_q == S_FLUSH) begin
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (stall_req_i) begin
                        // Hold fetch and IF/ID, inject a bubble into ID/EX.
                        pc_enable_o   = 1'b0;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
                S_HALT: begin
                    pc_next_o     = pc_cur_i;
                    pc_enable_o   = 1'b0;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    halted_o      = 1'b1;
                end
                default: begin
                    pc_next_o = RESET_PC;
                end
            endcase
        end
    end

endmodule
